// File: rtl/ram_program_loader_pkg.sv
// Shared types for the program RAM loader: sequencer states and the
// active-low strobe bundle with its idle value.
package ram_program_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADDR  = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DATA  = 3'd3,
    ST_WRITE = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  localparam logic STROBE_IDLE = 1'b1;

  typedef struct packed {
    logic n_load_addr;
    logic n_load_data;
    logic n_load_ram;
  } strobe_t;

  localparam strobe_t STROBES_IDLE = '{STROBE_IDLE, STROBE_IDLE, STROBE_IDLE};

endpackage

// File: rtl/ram_program_loader_if.sv
// Host handshake plus the bus/strobe outputs the loader muxes over the
// control block while it owns the bus.
interface ram_program_loader_if #(
  parameter int ADDR_W = 4
) ();
  logic              programming;
  logic              ui_valid;
  logic              ready;
  logic              done_load;
  logic              active;
  logic              read_ui_in;
  logic              addr_oe;
  logic [ADDR_W-1:0] addr_bus;
  logic              n_load_addr;
  logic              n_load_data;
  logic              n_load_ram;

  modport master (
    input  programming, ui_valid,
    output ready, done_load, active, read_ui_in, addr_oe, addr_bus,
           n_load_addr, n_load_data, n_load_ram
  );

  modport slave (
    output programming, ui_valid,
    input  ready, done_load, active, read_ui_in, addr_oe, addr_bus,
           n_load_addr, n_load_data, n_load_ram
  );
endinterface

// File: rtl/ram_program_loader_edge_detect.sv
// 1-bit rising-edge detector; rise is high in the cycle d first goes high.
module edge_detect_rise (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise
);
  logic d_q;

  always_ff @(posedge clk) begin
    if (!rst_n) d_q <= 1'b0;
    else        d_q <= d;
  end

  assign rise = d & ~d_q;
endmodule

// File: rtl/ram_program_loader.sv
// Programming-mode sequencer: walks ADDR/WAIT/DATA/WRITE per byte until
// RAM_BYTES locations are written, then parks in DONE.
module ram_program_loader
  import ram_program_loader_pkg::*;
#(
  parameter int RAM_BYTES = 16,
  parameter int ADDR_W    = 4,
  parameter int DATA_W    = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  ram_program_loader_if.master   lb
);

  if (RAM_BYTES > (1 << ADDR_W) || ADDR_W > DATA_W) begin : g_cfg_check
    $error("ram_program_loader: RAM_BYTES/ADDR_W/DATA_W inconsistent");
  end

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(RAM_BYTES - 1);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] count, count_nxt;
  logic              valid_rise;

  edge_detect_rise u_valid_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (lb.ui_valid),
    .rise  (valid_rise)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      count <= '0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
    end
  end

  // Dropping programming wins over everything, including a valid edge in WAIT.
  always_comb begin
    state_nxt = state;
    count_nxt = count;
    case (state)
      ST_IDLE: begin
        count_nxt = '0;
        if (lb.programming) state_nxt = ST_ADDR;
      end
      ST_ADDR: state_nxt = ST_WAIT;
      ST_WAIT: if (valid_rise) state_nxt = ST_DATA;
      ST_DATA: state_nxt = ST_WRITE;
      ST_WRITE: begin
        if (count == LAST_ADDR) state_nxt = ST_DONE;
        else begin
          count_nxt = count + 1'b1;
          state_nxt = ST_ADDR;
        end
      end
      ST_DONE: state_nxt = ST_DONE;
      default: begin
        state_nxt = ST_IDLE;
        count_nxt = '0;
      end
    endcase
    if (!lb.programming && state != ST_IDLE) begin
      state_nxt = ST_IDLE;
      count_nxt = '0;
    end
  end

  logic    ready, done_load, active, read_ui_in, addr_oe;
  strobe_t strb;

  // Outputs depend only on the state register, never on live inputs.
  always_comb begin
    ready      = 1'b0;
    done_load  = 1'b0;
    active     = 1'b0;
    read_ui_in = 1'b0;
    addr_oe    = 1'b0;
    strb       = STROBES_IDLE;
    case (state)
      ST_ADDR: begin
        active           = 1'b1;
        addr_oe          = 1'b1;
        strb.n_load_addr = ~STROBE_IDLE;
      end
      ST_WAIT: begin
        active = 1'b1;
        ready  = 1'b1;
      end
      ST_DATA: begin
        active           = 1'b1;
        read_ui_in       = 1'b1;
        strb.n_load_data = ~STROBE_IDLE;
      end
      ST_WRITE: begin
        active          = 1'b1;
        strb.n_load_ram = ~STROBE_IDLE;
      end
      ST_DONE: done_load = 1'b1;
      default: ;
    endcase
  end

  assign lb.ready       = ready;
  assign lb.done_load   = done_load;
  assign lb.active      = active;
  assign lb.read_ui_in  = read_ui_in;
  assign lb.addr_oe     = addr_oe;
  assign lb.addr_bus    = count;
  assign lb.n_load_addr = strb.n_load_addr;
  assign lb.n_load_data = strb.n_load_data;
  assign lb.n_load_ram  = strb.n_load_ram;

endmodule

// File: doc/ram_program_loader.md
Name: ram_program_loader

Overview:
- Sequencer that fills the 16-byte program RAM from the `ui_in` pins while programming mode is active.
- Drives the MAR address/data load strobes and the RAM write strobe, and gates `ui_in` onto the bus through `read_ui_in`.
- Handshakes with the external host using ready/valid.
- The top level muxes its strobes over the control-block strobes while `active` is high; the CPU stays halted in reset-equivalent idle.

Parameters:
- RAM_BYTES, 16, number of RAM locations to load; a power of two ≤ 2^ADDR_W.
- ADDR_W, 4, address width; equals the MAR address width.
- DATA_W, 8, bus and data width.

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rst_n  input  1  reset, synchronous, active-low
- programming  input  1  level from uio_in[0]; high requests a load session
- ui_valid  input  1  host strobe: byte on ui_in is valid
- ready  output  1  loader waiting for the next byte (ACTIVE-HIGH)
- done_load  output  1  all RAM_BYTES written (ACTIVE-HIGH)
- active  output  1  loader owns the bus and strobes; top-level mux select
- read_ui_in  output  1  gate ui_in onto the bus (ACTIVE-HIGH)
- addr_oe  output  1  drive addr_bus onto bus[ADDR_W-1:0], upper bits 0 (ACTIVE-HIGH)
- addr_bus  output  ADDR_W  current load address
- n_load_addr  output  1  MAR address load (ACTIVE-LOW)
- n_load_data  output  1  MAR data load (ACTIVE-LOW)
- n_load_ram  output  1  RAM write (ACTIVE-LOW)

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - state=IDLE, count=0, valid-edge register=0.
  - ready=0, done_load=0, active=0, read_ui_in=0, addr_oe=0.
  - n_load_addr=1, n_load_data=1, n_load_ram=1.
- All outputs are registered decodes of state; no combinational path from inputs to outputs.
- States:
  - IDLE: all strobes inactive. programming=1 → ADDR. count=0.
  - ADDR (1 cycle): active=1, addr_oe=1, n_load_addr=0, addr_bus=count → WAIT.
  - WAIT: active=1, ready=1. A rising edge of ui_valid (ui_valid=1 and the previous cycle's ui_valid=0) → DATA. A level held high from an earlier byte is ignored.
  - DATA (1 cycle): active=1, read_ui_in=1, n_load_data=0 → WRITE.
  - WRITE (1 cycle): active=1, n_load_ram=0. If count==RAM_BYTES-1 → DONE; else count+1 → ADDR.
  - DONE: active=0, done_load=1, held while programming=1. programming=0 → IDLE, count=0.
- Minimum 4 cycles per byte: ADDR, WAIT (≥1), DATA, WRITE.
- Mutual exclusion:
  - Exactly one of addr_oe / read_ui_in / none is high in any cycle.
  - At most one active-low strobe is low in any cycle.
- Abort: programming=0 in ADDR/WAIT/DATA/WRITE → IDLE next cycle.
  - All strobes deasserted; count=0.
  - A WRITE already in its cycle completes; no further writes occur.
  - done_load stays 0.
- Simultaneous events: programming falling in the same cycle as the ui_valid edge in WAIT → abort takes priority; no DATA cycle.
- count does not wrap; DONE is terminal until programming falls.
- Re-entry: programming falling then rising again restarts at address 0.
- rst_n=0 mid-session → IDLE next edge, identical to reset values, RAM contents unspecified/untouched.

Decomposition:
- Shared package: state encoding constants (IDLE, ADDR, WAIT, DATA, WRITE, DONE) and the active-low strobe idle value.
- Sub-module edge_detect_rise (1-bit rising-edge detector for ui_valid, synchronous active-low reset) is natural and reused for other host strobes.

Test Plan:
- Reset: hold rst_n=0 for 2 edges with programming=1 → all outputs at reset values; after release, ADDR with addr_bus=0, n_load_addr=0 on the next edge.
- Full load: programming=1, host supplies bytes 0x10..0x1F on each ready → 16 WRITE pulses at addr 0..15; RAM[i]=0x10+i; done_load=1 after the 16th WRITE; ready never high in DONE.
- Held valid: keep ui_valid=1 across two WAIT states → only one byte accepted; the second WAIT stays ready=1 until ui_valid drops and rises again.
- Abort: drop programming in WAIT at addr 5 → IDLE next cycle, no n_load_ram pulse for addr 5; re-raise → restart at addr 0, done_load=0.
- Priority: programming falls in the same cycle as the ui_valid edge → no read_ui_in/n_load_data pulse, state IDLE.
- Exclusivity monitor across all tests: never addr_oe&read_ui_in, never two active-low strobes low together, active=0 whenever done_load=1 or in IDLE.
